ap_ctrl_perf_monitor: RTL and testbench
=======================================

AP_CTRL_PERF_MONITOR -- requirements
Module: ap_ctrl_perf_monitor

Interface
REQ-001 Parameter NUM_CH, default 4: number of monitored ap_ctrl_hs channels (1..16).
REQ-002 Parameter CNT_W, default 32: width of all counters, timestamps and rd_data.
REQ-003 Parameter LAT_DEPTH, default 4: per-channel outstanding-start timestamp FIFO depth (power of 2, 2..16).
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 ap_start  input  NUM_CH  per-channel start, sampled only.
REQ-007 ap_ready  input  NUM_CH  per-channel ready; accept = ap_start & ap_ready.
REQ-008 ap_done  input  NUM_CH  per-channel done.
REQ-009 ap_continue  input  NUM_CH  per-channel continue; complete = ap_done & ap_continue.
REQ-010 finish  input  1  end-of-simulation or end-of-run marker.
REQ-011 rd_ch  input  $clog2(NUM_CH) (min 1)  readout channel select.
REQ-012 rd_sel  input  3  field: 0 txn count, 1 busy cycles, 2 stall cycles, 3 min latency, 4 max latency, 5 {outstanding, state}; 6-7 read 0.
REQ-013 rd_data  output  CNT_W  registered readout value.
REQ-014 ch_state  output  2*NUM_CH  per-channel FSM state, channel i at bits [2i+1:2i].
REQ-015 overflow  output  NUM_CH  sticky per-channel error flag.
REQ-016 frozen  output  1  sticky; high once finish is seen.

Function
REQ-017 Per-channel FSM encoding: IDLE=00, BUSY=01, STALL=10; 11 unreachable, recovers to IDLE.
REQ-018 IDLE->BUSY on accept; BUSY->STALL on ap_done & !ap_continue; STALL->BUSY or IDLE on complete (BUSY if outstanding after update >0); BUSY->IDLE on complete with outstanding after update =0 and no accept.
REQ-019 outstanding: +1 on accept, -1 on complete, unchanged on both same cycle; saturates at LAT_DEPTH and at 0.
REQ-020 Free-running cycle counter (CNT_W, wraps) starts at 0 after reset release.
REQ-021 Accept pushes current cycle count into channel FIFO; complete pops oldest entry present before that cycle; latency = now - popped value, modulo 2^CNT_W.
REQ-022 Push to full FIFO: entry dropped, overflow[i] set; pop from empty FIFO (orphan done): txn counted, no latency sample, overflow[i] set.
REQ-023 txn count +1 per complete; busy count +1 per cycle in BUSY; stall count +1 per cycle in STALL.
REQ-024 All counters saturate at all-ones; saturation sets overflow[i].
REQ-025 min latency initialised to all-ones, max latency to 0; updated on each latency sample.
REQ-026 rd_data valid one cycle after rd_ch/rd_sel sampled; rd_ch >= NUM_CH reads 0.
REQ-027 First cycle finish=1 sets frozen; from the next edge all FSMs, FIFOs and counters hold; readout remains live.
REQ-028 Channels are fully independent; simultaneous events on several channels all recorded same cycle.

Reset
REQ-029 reset low: all FSMs IDLE, outstanding 0, FIFOs empty, counters 0, min latency all-ones, rd_data 0, ch_state 0, overflow 0, frozen 0 -- immediately, without clock.
REQ-030 Reset asserted mid-transaction discards all in-flight state; first accept after release is treated as fresh.

Configuration
REQ-031 Macro AP_MON_LATENCY_EN: defined -> timestamp FIFOs and min/max latency tracking compiled in (REQ-021/022/025).
REQ-032 Undefined -> no FIFOs; rd_sel 3 and 4 read 0; outstanding, FSM, txn/busy/stall counters and counter-saturation overflow unchanged.

Verification
REQ-033 Ch0 accept at cycle 10, complete at cycle 17 -> txn=1, min=max=7, busy=7, state IDLE at cycle 18.
REQ-034 Ch1 done at cycle 20, continue held low until cycle 25 -> state STALL cycles 21-25, stall=5, txn=1 after cycle 25.
REQ-035 Ch2 five accepts with no done, LAT_DEPTH=4 -> overflow[2]=1 on fifth, outstanding=4.
REQ-036 Ch3 accept and complete same cycle with outstanding=1 -> outstanding stays 1, state BUSY, one latency sample taken.
REQ-037 finish at cycle 50 with ch0 BUSY -> frozen=1, busy count constant thereafter, rd_data still tracks rd_sel changes.
REQ-038 reset low at cycle 30 mid-transaction on all channels -> all outputs reset values same cycle; with AP_MON_LATENCY_EN undefined, rd_sel=3 reads 0.

Source files
------------

// File: rtl/ap_ctrl_perf_monitor.sv
// Per-channel ap_ctrl_hs monitor: transaction, busy and stall counters with a registered readout.
// Define AP_MON_LATENCY_EN to add start-timestamp FIFOs and min/max latency tracking.
module ap_ctrl_perf_monitor #(
  parameter  int unsigned NUM_CH    = 4,
  parameter  int unsigned CNT_W     = 32,
  parameter  int unsigned LAT_DEPTH = 4,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   ap_start,
  input  logic [NUM_CH-1:0]   ap_ready,
  input  logic [NUM_CH-1:0]   ap_done,
  input  logic [NUM_CH-1:0]   ap_continue,
  input  logic                finish,
  input  logic [CH_W-1:0]     rd_ch,
  input  logic [2:0]          rd_sel,
  output logic [CNT_W-1:0]    rd_data,
  output logic [2*NUM_CH-1:0] ch_state,
  output logic [NUM_CH-1:0]   overflow,
  output logic                frozen
);

  localparam int unsigned OUT_W = $clog2(LAT_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_BUSY  = 2'b01,
    S_STALL = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  logic [NUM_CH-1:0] acc, cmp, ovf_set;
  assign acc = ap_start & ap_ready;
  assign cmp = ap_done & ap_continue;

  logic [CNT_W-1:0] cyc_q;
  state_t           st_q    [NUM_CH];
  state_t           st_nxt  [NUM_CH];
  logic [OUT_W-1:0] out_q   [NUM_CH];
  logic [OUT_W-1:0] out_nxt [NUM_CH];
  logic [CNT_W-1:0] txn_q   [NUM_CH];
  logic [CNT_W-1:0] txn_nxt [NUM_CH];
  logic [CNT_W-1:0] busy_q  [NUM_CH];
  logic [CNT_W-1:0] busy_nxt[NUM_CH];
  logic [CNT_W-1:0] stall_q [NUM_CH];
  logic [CNT_W-1:0] stall_nxt[NUM_CH];
  logic [CNT_W-1:0] rd_mux;

`ifdef AP_MON_LATENCY_EN
  localparam int unsigned PTR_W = $clog2(LAT_DEPTH);

  logic [CNT_W-1:0] ts_q   [NUM_CH][LAT_DEPTH];
  logic [PTR_W-1:0] wp_q   [NUM_CH];
  logic [PTR_W-1:0] rp_q   [NUM_CH];
  logic [OUT_W-1:0] fcnt_q [NUM_CH];
  logic [CNT_W-1:0] lmin_q [NUM_CH];
  logic [CNT_W-1:0] lmax_q [NUM_CH];
  logic [CNT_W-1:0] lat    [NUM_CH];
  logic [NUM_CH-1:0] pop_ok, push_ok;

  // A full FIFO still accepts a push when the same cycle pops its oldest entry.
  always_comb begin
    pop_ok  = '0;
    push_ok = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pop_ok[i]  = cmp[i] && (fcnt_q[i] != '0);
      push_ok[i] = acc[i] && ((fcnt_q[i] != OUT_W'(LAT_DEPTH)) || pop_ok[i]);
      lat[i]     = cyc_q - ts_q[i][rp_q[i]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wp_q[i]   <= '0;
        rp_q[i]   <= '0;
        fcnt_q[i] <= '0;
        lmin_q[i] <= '1;
        lmax_q[i] <= '0;
      end
    end else if (!frozen) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (push_ok[i]) wp_q[i] <= wp_q[i] + 1'b1;
        if (pop_ok[i]) begin
          rp_q[i] <= rp_q[i] + 1'b1;
          if (lat[i] < lmin_q[i]) lmin_q[i] <= lat[i];
          if (lat[i] > lmax_q[i]) lmax_q[i] <= lat[i];
        end
        if (push_ok[i] && !pop_ok[i])      fcnt_q[i] <= fcnt_q[i] + 1'b1;
        else if (pop_ok[i] && !push_ok[i]) fcnt_q[i] <= fcnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!frozen) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (push_ok[i]) ts_q[i][wp_q[i]] <= cyc_q;
      end
    end
  end
`endif

  always_comb begin
    ovf_set = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      out_nxt[i] = out_q[i];
      if (acc[i] && !cmp[i] && (out_q[i] != OUT_W'(LAT_DEPTH)))
        out_nxt[i] = out_q[i] + 1'b1;
      else if (cmp[i] && !acc[i] && (out_q[i] != '0))
        out_nxt[i] = out_q[i] - 1'b1;

      st_nxt[i] = st_q[i];
      case (st_q[i])
        S_IDLE:  if (acc[i]) st_nxt[i] = S_BUSY;
        S_BUSY: begin
          if (cmp[i] && !acc[i] && (out_nxt[i] == '0)) st_nxt[i] = S_IDLE;
          else if (ap_done[i] && !ap_continue[i])      st_nxt[i] = S_STALL;
        end
        S_STALL: if (cmp[i]) st_nxt[i] = (out_nxt[i] != '0) ? S_BUSY : S_IDLE;
        default: st_nxt[i] = S_IDLE;
      endcase

      txn_nxt[i]   = txn_q[i];
      busy_nxt[i]  = busy_q[i];
      stall_nxt[i] = stall_q[i];
      if (cmp[i]) begin
        if (&txn_q[i]) ovf_set[i] = 1'b1;
        else           txn_nxt[i] = txn_q[i] + 1'b1;
      end
      if (st_q[i] == S_BUSY) begin
        if (&busy_q[i]) ovf_set[i] = 1'b1;
        else            busy_nxt[i] = busy_q[i] + 1'b1;
      end
      if (st_q[i] == S_STALL) begin
        if (&stall_q[i]) ovf_set[i] = 1'b1;
        else             stall_nxt[i] = stall_q[i] + 1'b1;
      end
`ifdef AP_MON_LATENCY_EN
      if ((acc[i] && !push_ok[i]) || (cmp[i] && !pop_ok[i])) ovf_set[i] = 1'b1;
`else
      if (acc[i] && !cmp[i] && (out_q[i] == OUT_W'(LAT_DEPTH))) ovf_set[i] = 1'b1;
`endif
    end
  end

  always_comb begin
    rd_mux = '0;
    if (32'(rd_ch) < NUM_CH) begin
      case (rd_sel)
        3'd0:    rd_mux = txn_q[rd_ch];
        3'd1:    rd_mux = busy_q[rd_ch];
        3'd2:    rd_mux = stall_q[rd_ch];
`ifdef AP_MON_LATENCY_EN
        3'd3:    rd_mux = lmin_q[rd_ch];
        3'd4:    rd_mux = lmax_q[rd_ch];
`endif
        3'd5:    rd_mux = CNT_W'({out_q[rd_ch], st_q[rd_ch]});
        default: rd_mux = '0;
      endcase
    end
  end

  always_comb begin
    ch_state = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) ch_state[2*i +: 2] = st_q[i];
  end

  // frozen gates updates from the edge after finish is seen; readout stays live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q    <= '0;
      frozen   <= 1'b0;
      overflow <= '0;
      rd_data  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        st_q[i]    <= S_IDLE;
        out_q[i]   <= '0;
        txn_q[i]   <= '0;
        busy_q[i]  <= '0;
        stall_q[i] <= '0;
      end
    end else begin
      rd_data <= rd_mux;
      if (finish) frozen <= 1'b1;
      if (!frozen) begin
        cyc_q    <= cyc_q + 1'b1;
        overflow <= overflow | ovf_set;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          st_q[i]    <= st_nxt[i];
          out_q[i]   <= out_nxt[i];
          txn_q[i]   <= txn_nxt[i];
          busy_q[i]  <= busy_nxt[i];
          stall_q[i] <= stall_nxt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Directed scoreboard bench for ap_ctrl_perf_monitor (4 channels, 32-bit counters, depth 4).
module tb_ap_ctrl_perf_monitor;

`ifdef AP_MON_LATENCY_EN
  localparam bit LAT_ON = 1'b1;
`else
  localparam bit LAT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ap_start = '0, ap_ready = '0, ap_done = '0, ap_continue = '0;
  logic        finish = 1'b0;
  logic [1:0]  rd_ch = '0;
  logic [2:0]  rd_sel = '0;
  logic [31:0] rd_data;
  logic [7:0]  ch_state;
  logic [3:0]  overflow;
  logic        frozen;

  ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(32), .LAT_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .finish(finish), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data), .ch_state(ch_state), .overflow(overflow), .frozen(frozen)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd;
    bit          ck;
    logic [7:0]  st;
    logic [3:0]  ov;
    logic        fz;
  } exp_t;

  exp_t sbq [$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] exp_st = '0;
  logic [3:0] exp_ov = '0;
  logic       exp_fz = 1'b0;
  logic       req_v = 1'b0;
  logic       rsp_v = 1'b0;

  // Read data appears one edge after the request is sampled.
  always @(posedge clk) rsp_v <= req_v;

  function automatic logic [31:0] lat(input logic [31:0] v);
    return LAT_ON ? v : 32'd0;
  endfunction

  task automatic check(input string name, input string what,
                       input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, what, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_v) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard: output presented with nothing expected, rd_data 0x%0h", rd_data);
        end else begin
          e = sbq.pop_front();
          check(e.name, "rd_data", rd_data, e.rd);
          if (e.ck) begin
            check(e.name, "ch_state", 32'(ch_state), 32'(e.st));
            check(e.name, "overflow", 32'(overflow), 32'(e.ov));
            check(e.name, "frozen",   32'(frozen),   32'(e.fz));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input logic [31:0] expv, input bit ck);
    exp_t e;
    e.name = name; e.rd = expv; e.ck = ck;
    e.st = exp_st; e.ov = exp_ov; e.fz = exp_fz;
    sbq.push_back(e);
  endtask

  // Status expectations (exp_st/ov/fz) describe the state after the read's edge.
  task automatic rd(input int unsigned ch, input logic [2:0] sel,
                    input logic [31:0] expv, input string name, input bit ck);
    push_exp(name, expv, ck);
    rd_ch  = 2'(ch);
    rd_sel = sel;
    req_v  = 1'b1;
    step();
    req_v  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    rd(0, 3'd0, 32'd0, "rst_txn", 1'b1);
    rst_n = 1'b1;

    // Ch0: accept, 7 busy cycles, complete
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
    step();
    ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
    repeat (6) step();
    ap_done[0] = 1'b1; ap_continue[0] = 1'b1;
    exp_st = 8'h00;
    rd(0, 3'd1, 32'd6, "a_busy_pre", 1'b1);
    ap_done[0] = 1'b0; ap_continue[0] = 1'b0;
    rd(0, 3'd0, 32'd1, "a_txn", 1'b0);
    rd(0, 3'd1, 32'd7, "a_busy", 1'b0);
    rd(0, 3'd3, lat(32'd7), "a_min", 1'b0);
    rd(0, 3'd4, lat(32'd7), "a_max", 1'b0);
    rd(0, 3'd5, 32'd0, "a_outst", 1'b0);

    // Ch1: done with continue held low for five stall cycles
    ap_start[1] = 1'b1; ap_ready[1] = 1'b1;
    step();
    ap_start[1] = 1'b0; ap_ready[1] = 1'b0;
    ap_done[1] = 1'b1; ap_continue[1] = 1'b0;
    exp_st = 8'h08;
    step();
    rd(1, 3'd5, 32'd6, "b_stall_state", 1'b1);
    repeat (3) step();
    ap_continue[1] = 1'b1;
    exp_st = 8'h00;
    rd(1, 3'd2, 32'd4, "b_stall_pre", 1'b1);
    ap_done[1] = 1'b0; ap_continue[1] = 1'b0;
    rd(1, 3'd2, 32'd5, "b_stall", 1'b0);
    rd(1, 3'd0, 32'd1, "b_txn", 1'b0);
    rd(1, 3'd1, 32'd1, "b_busy", 1'b0);
    rd(1, 3'd3, lat(32'd6), "b_min", 1'b0);

    // Ch2: five accepts without done saturate outstanding at 4
    ap_start[2] = 1'b1; ap_ready[2] = 1'b1;
    exp_st = 8'h10;
    repeat (3) step();
    rd(2, 3'd5, 32'd13, "c_out3", 1'b1);
    exp_ov = 4'b0100;
    rd(2, 3'd5, 32'd17, "c_out4", 1'b1);
    ap_start[2] = 1'b0; ap_ready[2] = 1'b0;
    rd(2, 3'd5, 32'd17, "c_out_sat", 1'b0);

    // Ch3: accept and complete in the same cycle with one outstanding
    ap_start[3] = 1'b1; ap_ready[3] = 1'b1;
    exp_st = 8'h50;
    step();
    ap_start[3] = 1'b0; ap_ready[3] = 1'b0;
    step();
    ap_start[3] = 1'b1; ap_ready[3] = 1'b1; ap_done[3] = 1'b1; ap_continue[3] = 1'b1;
    rd(3, 3'd5, 32'd5, "d_pre", 1'b1);
    ap_start[3] = 1'b0; ap_ready[3] = 1'b0; ap_done[3] = 1'b0; ap_continue[3] = 1'b0;
    rd(3, 3'd5, 32'd5, "d_out", 1'b0);
    rd(3, 3'd0, 32'd1, "d_txn", 1'b0);
    rd(3, 3'd3, lat(32'd2), "d_min", 1'b0);

    // Finish while ch0 busy: counters freeze, readout stays live
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
    exp_st = 8'h51;
    step();
    ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
    repeat (3) step();
    finish = 1'b1;
    exp_fz = 1'b1;
    rd(0, 3'd1, 32'd10, "e_busy_fin", 1'b1);
    finish = 1'b0;
    ap_done[0] = 1'b1; ap_continue[0] = 1'b1; ap_start[1] = 1'b1; ap_ready[1] = 1'b1;
    rd(0, 3'd5, 32'd5, "e_frz_out", 1'b1);
    ap_done[0] = 1'b0; ap_continue[0] = 1'b0; ap_start[1] = 1'b0; ap_ready[1] = 1'b0;
    repeat (4) step();
    rd(0, 3'd1, 32'd11, "e_busy_hold", 1'b1);
    rd(0, 3'd0, 32'd1, "e_txn_live", 1'b0);
    rd(1, 3'd2, 32'd5, "e_rd_live", 1'b0);

    // Asynchronous reset between edges clears every output before the next edge
    exp_st = 8'h00; exp_ov = 4'b0000; exp_fz = 1'b0;
    push_exp("f_async_rst", 32'd0, 1'b1);
    rd_ch = 2'd0; rd_sel = 3'd1; req_v = 1'b1;
    @(posedge clk);
    #1 req_v = 1'b0;
    #1 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Fresh simultaneous transactions on ch0, ch1, ch3 after reset
    ap_start = 4'b1011; ap_ready = 4'b1011;
    step();
    ap_start = 4'b0000; ap_ready = 4'b0000;
    step();
    step();
    ap_done = 4'b1011; ap_continue = 4'b1011;
    rd(0, 3'd1, 32'd2, "g_busy_pre", 1'b1);
    ap_done = 4'b0000; ap_continue = 4'b0000;
    rd(0, 3'd0, 32'd1, "g_txn0", 1'b0);
    rd(1, 3'd0, 32'd1, "g_txn1", 1'b0);
    rd(3, 3'd0, 32'd1, "g_txn3", 1'b0);
    rd(0, 3'd1, 32'd3, "g_busy0", 1'b0);
    rd(0, 3'd3, lat(32'd3), "g_min", 1'b0);
    rd(0, 3'd4, lat(32'd3), "g_max", 1'b0);
    rd(0, 3'd7, 32'd0, "g_sel7", 1'b0);
    rd(2, 3'd1, 32'd0, "g_ch2_busy", 1'b0);
    rd(2, 3'd5, 32'd0, "g_ch2_out", 1'b0);

    step();
    step();
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations never matched by an output, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
